// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle ALU (ADD..SHR in one step, MUL/DIV/MOD iterative); ports clk, reset(n), start/opcode/Sign_Mode/op_a/op_b in, busy/done/trap/ALU_Output/ALU_input_1/ALU_input_2 out
module alu_sequencer #(
  parameter int WIDTH = 20,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic             Sign_Mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALU_Output,
  output logic [WIDTH-1:0] ALU_input_1,
  output logic [WIDTH-1:0] ALU_input_2,
  output logic             trap
);
  localparam int CW = $clog2(ITER + 1);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] op_q, op_d;
  logic sm_q, sm_d, trap_q, trap_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, x_q, x_d, y_q, y_d, acc_q, acc_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] trial;
  logic [WIDTH-1:0] exec_res, sra;
  logic [4:0] sh;
  logic exec_trap, div_zero;
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign trap = done & trap_q;
  assign ALU_Output = res_q;
  assign ALU_input_1 = a_q;
  assign ALU_input_2 = b_q;
  always_comb begin
    sh = b_q[4:0];
    sra = $signed(a_q) >>> sh;
    div_zero = (op_q == 4'd8 || op_q == 4'd9) && b_q == '0;
    exec_trap = op_q > 4'd9 || div_zero;
    case (op_q)
      4'd0: exec_res = a_q + b_q;
      4'd1: exec_res = a_q - b_q;
      4'd2: exec_res = a_q & b_q;
      4'd3: exec_res = a_q | b_q;
      4'd4: exec_res = a_q ^ b_q;
      4'd5: exec_res = a_q << sh;
      4'd6: exec_res = sm_q ? sra : a_q >> sh;
      4'd8: exec_res = '1;
      4'd9: exec_res = a_q;
      default: exec_res = '0;
    endcase
    // restoring-division trial: shift next dividend bit into the remainder and subtract the divisor
    trial = {acc_q, x_q[WIDTH-1]} - {1'b0, b_q};
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    sm_d = sm_q;
    a_d = a_q;
    b_d = b_q;
    x_d = x_q;
    y_d = y_q;
    acc_d = acc_q;
    res_d = res_q;
    trap_d = trap_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: if (start) begin
        op_d = opcode;
        sm_d = Sign_Mode;
        a_d = op_a;
        b_d = op_b;
        x_d = op_a;
        y_d = op_b;
        acc_d = '0;
        cnt_d = '0;
        state_d = (opcode == 4'd7 || ((opcode == 4'd8 || opcode == 4'd9) && op_b != '0)) ? S_ITER : S_EXEC;
      end
      S_EXEC: begin
        res_d = exec_res;
        trap_d = exec_trap;
        state_d = S_DONE;
      end
      S_ITER: if (cnt_q == CW'(ITER)) begin
        res_d = op_q == 4'd8 ? x_q : acc_q;
        trap_d = 1'b0;
        state_d = S_DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == 4'd7) begin
          acc_d = acc_q + (y_q[0] ? x_q : '0);
          x_d = x_q << 1;
          y_d = y_q >> 1;
        end else begin
          // x holds the remaining dividend bits and collects quotient bits from the right
          acc_d = trial[WIDTH] ? {acc_q[WIDTH-2:0], x_q[WIDTH-1]} : trial[WIDTH-1:0];
          x_d = {x_q[WIDTH-2:0], ~trial[WIDTH]};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q <= '0;
      sm_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      x_q <= '0;
      y_q <= '0;
      acc_q <= '0;
      res_q <= '0;
      trap_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      sm_q <= sm_d;
      a_q <= a_d;
      b_q <= b_d;
      x_q <= x_d;
      y_q <= y_d;
      acc_q <= acc_d;
      res_q <= res_d;
      trap_q <= trap_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
